// File: rtl/alu_pkg.sv
// Shared operation encodings for the signed add/subtract pipeline.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDS = 2'b10;
    localparam logic [1:0] OP_SUBS = 2'b11;

endpackage

// File: rtl/addsub_segment.sv
// Combinational slice adder: one bit slice of the operands plus an incoming carry.
module addsub_segment #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign sum     = total_s[SW-1:0];
    assign cout    = total_s[SW];

endmodule

// File: rtl/signed_addsub_pipe.sv
// Segmented-carry signed add/subtract pipeline with optional saturation and
// a sticky overflow flag; one slice of the sum is resolved per stage.
module signed_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Inter-stage registers; entry k holds the state leaving stage k.
    logic             pv_r   [STAGES];
    logic [1:0]       pop_r  [STAGES];
    logic [WIDTH-1:0] px_r   [STAGES];
    logic [WIDTH-1:0] pym_r  [STAGES];
    logic [WIDTH-1:0] psum_r [STAGES];
    logic             pc_r   [STAGES];

    // Values presented to each stage's slice adder.
    logic             sv_s     [STAGES];
    logic [1:0]       sop_s    [STAGES];
    logic [WIDTH-1:0] sx_s     [STAGES];
    logic [WIDTH-1:0] sym_s    [STAGES];
    logic [WIDTH-1:0] ssum_s   [STAGES];
    logic             sc_s     [STAGES];
    logic [SW-1:0]    seg_sum_s[STAGES];
    logic             seg_c_s  [STAGES];
    logic [WIDTH-1:0] merged_s [STAGES];

    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] fin_s;
    logic             ovf_s;
    logic             sat_s;
    logic             stall_s;
    logic             adv_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] s_r;
    logic             overflow_r;
    logic             negative_r;
    logic             zero_r;
    logic             cout_r;
    logic             sticky_r;

    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        return {neg, {(WIDTH-1){~neg}}};
    endfunction

    assign stall_s    = out_valid_r && !out_ready;
    assign adv_s      = !stall_s;
    assign in_ready   = adv_s;
    assign out_valid  = out_valid_r;
    assign s          = s_r;
    assign overflow   = overflow_r;
    assign negative   = negative_r;
    assign zero       = zero_r;
    assign cout       = cout_r;
    assign ovf_sticky = sticky_r;

    // Stage inputs: stage 0 from the ports (subtract folds into ~y plus carry-in), later stages from registers.
    always_comb begin
        sv_s[0]   = in_valid;
        sop_s[0]  = op;
        sx_s[0]   = x;
        ssum_s[0] = '0;
        case (op)
            OP_SUB, OP_SUBS: begin
                sym_s[0] = ~y;
                sc_s[0]  = 1'b1;
            end
            OP_ADD, OP_ADDS: begin
                sym_s[0] = y;
                sc_s[0]  = 1'b0;
            end
            default: begin
                sym_s[0] = y;
                sc_s[0]  = 1'b0;
            end
        endcase
        for (int k = 1; k < STAGES; k++) begin
            sv_s[k]   = pv_r[k-1];
            sop_s[k]  = pop_r[k-1];
            sx_s[k]   = px_r[k-1];
            sym_s[k]  = pym_r[k-1];
            ssum_s[k] = psum_r[k-1];
            sc_s[k]   = pc_r[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        addsub_segment #(.SW(SW)) u_seg (
            .a    (sx_s[g][g*SW +: SW]),
            .b    (sym_s[g][g*SW +: SW]),
            .cin  (sc_s[g]),
            .sum  (seg_sum_s[g]),
            .cout (seg_c_s[g])
        );
    end

    // Splice each stage's freshly computed slice into the partial sum it carries.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            merged_s[k]               = ssum_s[k];
            merged_s[k][k*SW +: SW]   = seg_sum_s[k];
        end
    end

    // Overflow uses the effective addend sign, which covers both add and subtract.
    always_comb begin
        raw_s = merged_s[LAST];
        ovf_s = (sx_s[LAST][WIDTH-1] == sym_s[LAST][WIDTH-1]) &&
                (raw_s[WIDTH-1] != sx_s[LAST][WIDTH-1]);
        case (sop_s[LAST])
            OP_ADDS, OP_SUBS: sat_s = 1'b1;
            OP_ADD,  OP_SUB:  sat_s = 1'b0;
            default:          sat_s = 1'b0;
        endcase
        if (sat_s && ovf_s) begin
            fin_s = sat_value(sx_s[LAST][WIDTH-1]);
        end else begin
            fin_s = raw_s;
        end
    end

    // Pipeline advance; everything freezes while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            s_r         <= '0;
            overflow_r  <= 1'b0;
            negative_r  <= 1'b0;
            zero_r      <= 1'b0;
            cout_r      <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                pv_r[k]   <= 1'b0;
                pop_r[k]  <= 2'b00;
                px_r[k]   <= '0;
                pym_r[k]  <= '0;
                psum_r[k] <= '0;
                pc_r[k]   <= 1'b0;
            end
        end else if (adv_s) begin
            for (int k = 0; k < LAST; k++) begin
                pv_r[k]   <= sv_s[k];
                pop_r[k]  <= sop_s[k];
                px_r[k]   <= sx_s[k];
                pym_r[k]  <= sym_s[k];
                psum_r[k] <= merged_s[k];
                pc_r[k]   <= seg_c_s[k];
            end
            out_valid_r <= sv_s[LAST];
            if (sv_s[LAST]) begin
                s_r        <= fin_s;
                overflow_r <= ovf_s;
                negative_r <= fin_s[WIDTH-1];
                zero_r     <= (fin_s == '0);
                cout_r     <= seg_c_s[LAST];
            end
        end
    end

    // Sticky overflow: a delivered overflow outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else if (out_valid_r && out_ready && overflow_r) begin
            sticky_r <= 1'b1;
        end else if (clr_sticky) begin
            sticky_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Scoreboard bench for signed_addsub_pipe at WIDTH=8, STAGES=2 with directed vectors.
module tb_signed_addsub_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] s;
        logic       ovf;
        logic       neg;
        logic       zero;
        logic       cout;
        bit         chk;
        int         exp_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] s;
    logic       overflow;
    logic       negative;
    logic       zero;
    logic       cout;
    logic       clr_sticky;
    logic       ovf_sticky;

    exp_t       sb[$];
    exp_t       e;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         stall_lo = -100;
    bit         force_hold = 1'b0;
    bit         held = 1'b0;
    logic [7:0] held_s;

    signed_addsub_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s          (s),
        .overflow   (overflow),
        .negative   (negative),
        .zero       (zero),
        .cout       (cout),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: a 3-cycle window starting at stall_lo, or held low on request.
    always @(posedge clk) begin
        #1;
        out_ready = !(force_hold || (cyc >= stall_lo && cyc < stall_lo + 3));
    end

    // Monitor: pop and compare on every delivery; during stalls check hold behaviour.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (out_valid && out_ready) begin
            held = 1'b0;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got s=%h, required no delivery", s);
            end else begin
                e = sb.pop_front();
                if ({s, overflow, negative, zero, cout} !== {e.s, e.ovf, e.neg, e.zero, e.cout}) begin
                    n_err++;
                    $display("FAIL result: got s=%h ovf=%b neg=%b zero=%b cout=%b, required s=%h ovf=%b neg=%b zero=%b cout=%b",
                             s, overflow, negative, zero, cout, e.s, e.ovf, e.neg, e.zero, e.cout);
                end
                if (e.chk) begin
                    n_vec++;
                    if (cyc != e.exp_cyc) begin
                        n_err++;
                        $display("FAIL latency: got cycle %0d, required cycle %0d", cyc, e.exp_cyc);
                    end
                end
            end
        end else if (out_valid && !out_ready) begin
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL in_ready_stall: got %b, required 0", in_ready);
            end
            if (held) begin
                n_vec++;
                if (s !== held_s) begin
                    n_err++;
                    $display("FAIL stall_hold: got s=%h, required s=%h", s, held_s);
                end
            end
            held_s = s;
            held   = 1'b1;
        end else begin
            held = 1'b0;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at a negedge; holds the operands until accepted, then returns one negedge later.
    task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic eo, input logic en,
                        input logic ez, input logic ec, input bit push, input bit chk);
        int n = 0;
        op = o;
        x = a;
        y = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
        end else if (push) begin
            sb.push_back('{s: es, ovf: eo, neg: en, zero: ez, cout: ec, chk: chk, exp_cyc: cyc + 2});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        x          = 8'h00;
        y          = 8'h00;
        op         = 2'b00;
        clr_sticky = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", {15'd0, out_valid}, 16'h0000);
        check("reset_s", {8'h00, s}, 16'h0000);
        check("reset_flags", {12'h000, overflow, negative, zero, cout}, 16'h0000);
        check("reset_sticky", {15'd0, ovf_sticky}, 16'h0000);
        check("reset_in_ready", {15'd0, in_ready}, 16'h0001);
        rst = 1'b0;
        @(negedge clk);

        // Main function, back to back, latency checked.
        send(OP_ADD,  8'h64, 8'h32, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send(OP_ADDS, 8'h64, 8'h32, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(OP_SUBS, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send(OP_SUB,  8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        send(OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        send(OP_ADDS, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send(OP_SUBS, 8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(OP_ADD,  8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send(OP_ADDS, 8'h40, 8'hF0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(OP_SUBS, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Four ops with a 3-cycle consumer stall in the middle.
        stall_lo = cyc + 3;
        send(OP_ADD,  8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(OP_SUB,  8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(OP_ADDS, 8'h70, 8'h70, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(OP_SUBS, 8'h90, 8'h70, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        // Reset with two operations in flight.
        force_hold = 1'b1;
        @(negedge clk);
        send(OP_ADD, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(OP_SUB, 8'h33, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("inflight_out_valid", {15'd0, out_valid}, 16'h0001);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {15'd0, out_valid}, 16'h0000);
        check("async_rst_s", {8'h00, s}, 16'h0000);
        check("async_rst_flags", {12'h000, overflow, negative, zero, cout}, 16'h0000);
        check("async_rst_sticky", {15'd0, ovf_sticky}, 16'h0000);
        check("async_rst_in_ready", {15'd0, in_ready}, 16'h0001);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        force_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_output", {15'd0, out_valid}, 16'h0000);
        end

        // Normal latency after reset; its overflow sets the sticky flag.
        send(OP_ADD, 8'h64, 8'h32, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check("sticky_set", {15'd0, ovf_sticky}, 16'h0001);

        // Clear coinciding with an overflowing delivery: set wins.
        send(OP_ADDS, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("sticky_test_out_valid", {15'd0, out_valid}, 16'h0001);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("sticky_set_wins", {15'd0, ovf_sticky}, 16'h0001);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("sticky_cleared", {15'd0, ovf_sticky}, 16'h0000);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signed_addsub_pipe.md
SIGNED_ADDSUB_PIPE -- requirements
Module: signed_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2, number of pipeline segments; SHALL be >= 1 and divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 x, y  input  WIDTH each  two's-complement operands.
REQ-008 op  input  2  00 ADD, 01 SUB, 10 ADDS (saturating add), 11 SUBS (saturating sub).
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 s  output  WIDTH  result.
REQ-012 overflow, negative, zero, cout  output  1 each  per-result flags.
REQ-013 clr_sticky  input  1  clears ovf_sticky.
REQ-014 ovf_sticky  output  1  set by any delivered overflowing result.

Function
REQ-015 Accept on in_valid && in_ready; deliver on out_valid && out_ready.
REQ-016 Stall = out_valid && !out_ready; in_ready SHALL equal !stall; the whole pipeline SHALL hold all state while stalled.
REQ-017 Latency exactly STAGES cycles from accept to out_valid when unstalled; throughput one operation per cycle; order preserved.
REQ-018 Stage k (0..STAGES-1) SHALL add bit slice k of width WIDTH/STAGES, using the registered carry from stage k-1; lower slices already computed travel with the operation; upper operand slices are delayed alongside.
REQ-019 SUB/SUBS compute x + ~y + 1; the carry-in of stage 0 is op[0].
REQ-020 cout = carry out of MSB (for SUB: 1 = no borrow).
REQ-021 Raw overflow: ADD types: sign(x)==sign(y) && sign(raw)!=sign(x); SUB types: sign(x)!=sign(y) && sign(raw)!=sign(x).
REQ-022 ADD/SUB: s = raw sum mod 2^WIDTH.
REQ-023 ADDS/SUBS on overflow: s = 2^(WIDTH-1)-1 if sign(x)=0, else -2^(WIDTH-1); no overflow: s = raw.
REQ-024 overflow reports raw overflow in all modes; negative = s[WIDTH-1]; zero = (s==0); both computed on the final (possibly saturated) s.
REQ-025 ovf_sticky SHALL set on a delivery with overflow=1; clr_sticky SHALL clear it; simultaneous set and clear: set wins.
REQ-026 Bubbles (no accept) SHALL propagate as invalid slots; out_valid deasserts when the bubble reaches the output.
REQ-027 s and flags SHALL stay stable while out_valid && !out_ready.

Reset
REQ-028 On rst all valid bits, ovf_sticky, s and flags SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; none emerge after release.
REQ-030 in_ready SHALL be 1 during and after reset.

Structure
REQ-031 Op encodings (ADD, SUB, ADDS, SUBS) SHALL live in a shared package alu_pkg as named constants.
REQ-032 One sub-module addsub_segment (parametrised slice width: slice sum and carry out, combinational) SHALL be instantiated once per stage.
REQ-033 Saturation/flag logic SHALL sit after the final stage, with its output registered and part of the last pipeline register.

Verification (WIDTH=8, STAGES=2)
REQ-034 ADD 0x64+0x32 -> s=0x96, overflow=1, negative=1, zero=0, cout=0, out_valid 2 cycles after accept; ADDS same operands -> s=0x7F, overflow=1, negative=0.
REQ-035 SUB 0x80-0x01 -> s=0x7F, overflow=1, cout=1; SUBS -> s=0x80, negative=1.
REQ-036 SUB 0x05-0x05 -> s=0x00, zero=1, cout=1, overflow=0.
REQ-037 Back-to-back 4 ops, out_ready low 3 cycles mid-stream -> in_ready low during stall, s held, all 4 results delivered in order, no loss or duplication.
REQ-038 rst asserted with 2 ops in flight -> out_valid=0 asynchronously; no result after release; next op has normal latency.
REQ-039 Overflowing delivery sets ovf_sticky; clr_sticky in the same cycle as another overflowing delivery -> ovf_sticky stays 1; clr_sticky alone -> 0 next cycle.
